// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable prescaler, h/v counters and registered sync/display decode.
// Optional blink strobe built only when VGA_TIMING_STROBE_EN is defined; otherwise strobe is tied low.
module vga_timing_gen #(
  parameter int CLK_DIV       = 4,
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int SYNC_POL      = 0,
  parameter int STROBE_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  output logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       display_area,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start,
  output logic       strobe
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int PW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic       ACT      = (SYNC_POL != 0);

  logic [PW-1:0] prescaler;
  logic [9:0]    h_count, v_count;
  logic [9:0]    h_next, v_next;
  logic          h_wrap, v_wrap;

  assign h_wrap  = (h_count == H_LAST);
  assign v_wrap  = (v_count == V_LAST);
  assign pixel_x = h_count;
  assign pixel_y = v_count;

  always_comb begin
    h_next = h_count + 10'd1;
    v_next = v_count;
    if (h_wrap) begin
      h_next = '0;
      v_next = v_wrap ? '0 : v_count + 10'd1;
    end
  end

  // enable is registered off the prescaler wrap, so it lands in clks CLK_DIV, 2*CLK_DIV, ...
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      enable    <= 1'b0;
    end else begin
      prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PW'(1);
      enable    <= (prescaler == PRE_LAST);
    end
  end

  // Counters and decodes move together on the edge that closes an enable cycle,
  // so everything a downstream stage samples under enable is mutually consistent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count      <= H_LAST;
      v_count      <= V_LAST;
      display_area <= 1'b0;
      hsync        <= ~ACT;
      vsync        <= ~ACT;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= enable && h_wrap && v_wrap;
      if (enable) begin
        h_count      <= h_next;
        v_count      <= v_next;
        display_area <= (h_next < H_VIS) && (v_next < V_VIS);
        hsync        <= (h_next >= HS_START && h_next < HS_END) ? ACT : ~ACT;
        vsync        <= (v_next >= VS_START && v_next < VS_END) ? ACT : ~ACT;
      end
    end
  end

`ifdef VGA_TIMING_STROBE_EN
  localparam logic [7:0] SF_LAST = 8'(STROBE_FRAMES - 1);
  logic [7:0] frame_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      strobe    <= 1'b0;
    end else if (enable && h_wrap && v_wrap) begin
      if (frame_cnt == SF_LAST) begin
        frame_cnt <= '0;
        strobe    <= ~strobe;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end
`else
  assign strobe = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunken raster (CLK_DIV=2, SYNC_POL=1) plus a default-sized instance,
// both compared every clk against a linear-position model; table vectors, reset sequences, random resets.
module tb_vga_timing_gen;

  // small raster: 24 x 13, sync active-high
  localparam int SD = 2, SHV = 16, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVV = 8, SVF = 1, SVS = 2, SVB = 2, SPOL = 1, SSF = 3;
  localparam int DSF = 30;
`ifdef VGA_TIMING_STROBE_EN
  localparam bit STB = 1'b1;
`else
  localparam bit STB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       s_en, s_hs, s_vs, s_da, s_fs, s_st;
  logic [9:0] s_px, s_py;
  logic       d_en, d_hs, d_vs, d_da, d_fs, d_st;
  logic [9:0] d_px, d_py;

  vga_timing_gen #(
    .CLK_DIV(SD), .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .SYNC_POL(SPOL), .STROBE_FRAMES(SSF)
  ) u_small (
    .clk(clk), .reset(reset), .enable(s_en), .hsync(s_hs), .vsync(s_vs),
    .display_area(s_da), .pixel_x(s_px), .pixel_y(s_py), .frame_start(s_fs), .strobe(s_st)
  );

  vga_timing_gen u_dflt (
    .clk(clk), .reset(reset), .enable(d_en), .hsync(d_hs), .vsync(d_vs),
    .display_area(d_da), .pixel_x(d_px), .pixel_y(d_py), .frame_start(d_fs), .strobe(d_st)
  );

  typedef struct {
    int en, px, py, da, hs, vs, fs, st;
  } exp_t;

  typedef struct {
    int k;
    int en, px, py, da, hs, vs, fs;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;  // rising edges since reset release

  // Raster as a linear pixel index: the a-th advance edge moves the position a steps past (H_TOTAL-1, V_TOTAL-1).
  function automatic exp_t model(int kk, bit rst, int D, int HV, int HF, int HS, int HB,
                                 int VV, int VF, int VS, int VB, int POL, int SF);
    exp_t e;
    int ht, vt, f, a, l, h, v, w;
    ht = HV + HF + HS + HB;
    vt = VV + VF + VS + VB;
    f  = ht * vt;
    if (rst || kk == 0) begin
      e.en = 0; e.px = ht - 1; e.py = vt - 1; e.da = 0;
      e.hs = 1 - POL; e.vs = 1 - POL; e.fs = 0; e.st = 0;
      return e;
    end
    a = (kk - 1) / D;
    l = (f - 1 + a) % f;
    h = l % ht;
    v = l / ht;
    w = (a == 0) ? 0 : (a - 1) / f + 1;
    e.en = (kk % D == 0) ? 1 : 0;
    e.px = h;
    e.py = v;
    e.da = (h < HV && v < VV) ? 1 : 0;
    e.hs = (h >= HV + HF && h < HV + HF + HS) ? POL : 1 - POL;
    e.vs = (v >= VV + VF && v < VV + VF + VS) ? POL : 1 - POL;
    e.fs = (a >= 1 && (kk - 1) % D == 0 && l == 0) ? 1 : 0;
    e.st = STB ? (w / SF) % 2 : 0;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%0d want=%0d", nm, k, act, exp_v);
    end
  endtask

  task automatic check_all();
    exp_t es, ed;
    es = model(k, reset, SD, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, SPOL, SSF);
    ed = model(k, reset, 4, 640, 16, 96, 48, 480, 10, 2, 33, 0, DSF);
    chk("s_enable", int'(s_en), es.en);  chk("s_pixel_x", int'(s_px), es.px);
    chk("s_pixel_y", int'(s_py), es.py); chk("s_display", int'(s_da), es.da);
    chk("s_hsync", int'(s_hs), es.hs);   chk("s_vsync", int'(s_vs), es.vs);
    chk("s_frame_start", int'(s_fs), es.fs); chk("s_strobe", int'(s_st), es.st);
    chk("d_enable", int'(d_en), ed.en);  chk("d_pixel_x", int'(d_px), ed.px);
    chk("d_pixel_y", int'(d_py), ed.py); chk("d_display", int'(d_da), ed.da);
    chk("d_hsync", int'(d_hs), ed.hs);   chk("d_vsync", int'(d_vs), ed.vs);
    chk("d_frame_start", int'(d_fs), ed.fs); chk("d_strobe", int'(d_st), ed.st);
  endtask

  task automatic step();
    @(posedge clk);
    k = reset ? 0 : k + 1;
    @(negedge clk);
    check_all();
  endtask

  vec_t vt[$];
  int   rst_left;

  initial begin
    // hand-derived checkpoints for the small raster (k = clk number after release)
    vt.push_back('{1,   0, 23, 12, 0, 0, 0, 0});
    vt.push_back('{2,   1, 23, 12, 0, 0, 0, 0});
    vt.push_back('{3,   0,  0,  0, 1, 0, 0, 1});
    vt.push_back('{4,   1,  0,  0, 1, 0, 0, 0});
    vt.push_back('{5,   0,  1,  0, 1, 0, 0, 0});
    vt.push_back('{33,  0, 15,  0, 1, 0, 0, 0});
    vt.push_back('{35,  0, 16,  0, 0, 0, 0, 0});
    vt.push_back('{38,  1, 17,  0, 0, 0, 0, 0});
    vt.push_back('{39,  0, 18,  0, 0, 1, 0, 0});
    vt.push_back('{44,  1, 20,  0, 0, 1, 0, 0});
    vt.push_back('{45,  0, 21,  0, 0, 0, 0, 0});
    vt.push_back('{50,  1, 23,  0, 0, 0, 0, 0});
    vt.push_back('{51,  0,  0,  1, 1, 0, 0, 0});
    vt.push_back('{435, 0,  0,  9, 0, 0, 1, 0});
    vt.push_back('{457, 0, 11,  9, 0, 0, 1, 0});
    vt.push_back('{531, 0,  0, 11, 0, 0, 0, 0});
    vt.push_back('{625, 0, 23, 12, 0, 0, 0, 0});
    vt.push_back('{627, 0,  0,  0, 1, 0, 0, 1});
    vt.push_back('{628, 1,  0,  0, 1, 0, 0, 0});

    reset = 1'b1;
    repeat (3) step();
    chk("rst_s_pixel_x", int'(s_px), 23);
    chk("rst_d_pixel_y", int'(d_py), 524);
    reset = 1'b0;

    foreach (vt[i]) begin
      while (k < vt[i].k) step();
      chk("tbl_enable",  int'(s_en), vt[i].en);
      chk("tbl_pixel_x", int'(s_px), vt[i].px);
      chk("tbl_pixel_y", int'(s_py), vt[i].py);
      chk("tbl_display", int'(s_da), vt[i].da);
      chk("tbl_hsync",   int'(s_hs), vt[i].hs);
      chk("tbl_vsync",   int'(s_vs), vt[i].vs);
      chk("tbl_fstart",  int'(s_fs), vt[i].fs);
    end

    // reset mid-frame at small-raster pixel (5,3) of the second frame
    while (k < 781) step();
    chk("mid_pixel_x", int'(s_px), 5);
    chk("mid_pixel_y", int'(s_py), 3);
    reset = 1'b1;
    #1;
    chk("async_s_pixel_x", int'(s_px), 23);
    chk("async_s_hsync", int'(s_hs), 0);
    chk("async_d_hsync", int'(d_hs), 1);
    chk("async_d_pixel_x", int'(d_px), 799);
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rel_s_enable", int'(s_en), 0);
    step();
    chk("rel_s_enable2", int'(s_en), 1);
    chk("rel_s_pixel_x", int'(s_px), 23);
    step();
    chk("rel_s_fstart", int'(s_fs), 1);
    chk("rel_s_pixel_x0", int'(s_px), 0);

    // unbroken run: several small frames (strobe toggles) and the first default lines
    repeat (5000) step();

    // random short resets sprinkled in
    rst_left = 0;
    repeat (15000) begin
      step();
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset = 1'b0;
      end else if ($urandom_range(0, 1999) < 2) begin
        reset = 1'b1;
        rst_left = $urandom_range(1, 4);
        #1;
        check_all();
      end
    end
    reset = 1'b0;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
